// File: rtl/fetch_prefetch_queue_if.sv
// Fetch-unit bus bundle: memory read port, redirect input and the instruction
// valid/ready output. The master modport is the fetch unit; slave is its environment.
interface fetch_prefetch_queue_if #(
  parameter int unsigned DataSize = 32,
  parameter int unsigned Depth    = 4
);
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic                mem_rd_en;
  logic [DataSize-1:0] mem_addr;
  logic                mem_ack;
  logic [31:0]         mem_rd_data;
  logic                redirect;
  logic [DataSize-1:0] redirect_pc;
  logic                inst_valid;
  logic                inst_ready;
  logic [31:0]         inst;
  logic [DataSize-1:0] inst_pc;
  logic [CountW-1:0]   count;

  modport master (
    output mem_rd_en, mem_addr, inst_valid, inst, inst_pc, count,
    input  mem_ack, mem_rd_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, inst_valid, inst, inst_pc, count,
    output mem_ack, mem_rd_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch unit with a prefetch FIFO. Fetches sequential 32-bit words
// ahead of the consumer, queues {inst, pc} pairs and hands them out through a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
module fetch_prefetch_queue #(
  parameter int unsigned        DataSize = 32,
  parameter int unsigned        Depth    = 4,
  parameter logic [DataSize-1:0] ResetPc = '0
) (
  input logic                    clk_i,
  input logic                    rst_i,
  fetch_prefetch_queue_if.master bus_io
);
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = $clog2(Depth + 1);
  localparam logic [DataSize-1:0] AlignMask = ~DataSize'(3);

  typedef enum logic [1:0] {StIdle, StRequest, StDiscard} state_e;

  state_e              state_q, state_d;
  logic [DataSize-1:0] fetch_pc_q, fetch_pc_d;
  logic [DataSize-1:0] pend_addr_q, pend_addr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [31:0]         inst_mem_q [Depth];
  logic [DataSize-1:0] pc_mem_q [Depth];

  logic                push, pop;
  logic [CountW-1:0]   count_after_push;

  // Next-state logic: fetch FSM, pointers and occupancy; redirect overrides push/pop.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    pend_addr_d      = pend_addr_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    push             = 1'b0;
    pop              = (count_q != '0) && bus_io.inst_ready;
    count_after_push = count_q + CountW'(1) - CountW'(pop);

    unique case (state_q)
      StIdle: begin
        if (!bus_io.redirect && (count_q < CountW'(Depth))) state_d = StRequest;
      end
      StRequest: begin
        if (bus_io.redirect) begin
          // An acked word is stale once redirected; otherwise wait out the request.
          if (bus_io.mem_ack) begin
            state_d = StIdle;
          end else begin
            state_d     = StDiscard;
            pend_addr_d = fetch_pc_q;
          end
        end else if (bus_io.mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + DataSize'(4);
          if (count_after_push >= CountW'(Depth)) state_d = StIdle;
        end
      end
      StDiscard: begin
        if (bus_io.mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus_io.redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = bus_io.redirect_pc & AlignMask;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CountW'(push) - CountW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      fetch_pc_q  <= ResetPc & AlignMask;
      pend_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head reads zero when empty after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= bus_io.mem_rd_data;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Outputs: DISCARD keeps presenting the abandoned address until its ack.
  always_comb begin
    bus_io.mem_rd_en  = (state_q != StIdle);
    bus_io.mem_addr   = (state_q == StDiscard) ? pend_addr_q : fetch_pc_q;
    bus_io.inst_valid = (count_q != '0);
    bus_io.inst       = inst_mem_q[rd_ptr_q];
    bus_io.inst_pc    = pc_mem_q[rd_ptr_q];
    bus_io.count      = count_q;
  end
endmodule
